// File: rtl/vr_fifo_flags_if.sv
// Valid/ready stream interface between a producer, the FIFO and a consumer.
// The FIFO sits on the slave modport; the stimulus side uses master.
interface vr_fifo_flags_if #(
  parameter int unsigned D_WIDTH = 6
);
  logic               up_valid;
  logic               up_ready;
  logic [D_WIDTH-1:0] up_data;
  logic               down_valid;
  logic               down_ready;
  logic [D_WIDTH-1:0] down_data;

  modport master (
    output up_valid,
    output up_data,
    input  up_ready,
    input  down_valid,
    input  down_data,
    output down_ready
  );

  modport slave (
    input  up_valid,
    input  up_data,
    output up_ready,
    output down_valid,
    output down_data,
    input  down_ready
  );
endinterface

// File: rtl/vr_fifo_flags.sv
// Valid/ready synchronous FIFO, first-word-fall-through, with fill level,
// almost-full/almost-empty flags and a synchronous flush.
module vr_fifo_flags #(
  parameter int unsigned D_WIDTH  = 6,
  parameter int unsigned A_WIDTH  = 2,
  parameter int unsigned AF_LEVEL = 3,
  parameter int unsigned AE_LEVEL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  vr_fifo_flags_if.slave   bus,
  output logic [A_WIDTH:0] level,
  output logic             almost_full,
  output logic             almost_empty
);

  localparam int unsigned      DEPTH   = 1 << A_WIDTH;
  localparam logic [A_WIDTH:0] DEPTH_L = {1'b1, {A_WIDTH{1'b0}}};
  localparam logic [A_WIDTH:0] AF_L    = AF_LEVEL[A_WIDTH:0];
  localparam logic [A_WIDTH:0] AE_L    = AE_LEVEL[A_WIDTH:0];

  logic [D_WIDTH-1:0] r_mem [DEPTH];
  logic [A_WIDTH-1:0] r_wr_ptr, w_wr_ptr_d;
  logic [A_WIDTH-1:0] r_rd_ptr, w_rd_ptr_d;
  logic [A_WIDTH:0]   r_level, w_level_d;
  logic               w_push, w_pop;

  // Handshake decode; flush blocks both transfers so nothing is silently lost.
  always_comb begin
    bus.up_ready   = (r_level != DEPTH_L) && !flush;
    bus.down_valid = (r_level != '0);
    bus.down_data  = r_mem[r_rd_ptr];
    w_push         = bus.up_valid && bus.up_ready;
    w_pop          = bus.down_valid && bus.down_ready && !flush;
  end

  // Next-state for pointers and the separate occupancy counter.
  always_comb begin
    w_wr_ptr_d = r_wr_ptr;
    w_rd_ptr_d = r_rd_ptr;
    w_level_d  = r_level;
    if (flush) begin
      w_wr_ptr_d = '0;
      w_rd_ptr_d = '0;
      w_level_d  = '0;
    end else begin
      if (w_push) w_wr_ptr_d = r_wr_ptr + A_WIDTH'(1);
      if (w_pop)  w_rd_ptr_d = r_rd_ptr + A_WIDTH'(1);
      unique case ({w_push, w_pop})
        2'b10:   w_level_d = r_level + (A_WIDTH + 1)'(1);
        2'b01:   w_level_d = r_level - (A_WIDTH + 1)'(1);
        default: w_level_d = r_level;
      endcase
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_d;
      r_rd_ptr <= w_rd_ptr_d;
      r_level  <= w_level_d;
    end
  end

  // Storage array; not reset, contents are only visible through valid pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.up_data;
  end

  // Flags are compares on the registered level, so they move with level.
  always_comb begin
    level        = r_level;
    almost_full  = (r_level >= AF_L);
    almost_empty = (r_level <= AE_L);
  end

endmodule

// File: tb/tb_vr_fifo_flags.sv
// Scoreboard bench for vr_fifo_flags: accepted words are queued at push time
// and compared against down_data when the FIFO pops them.
module tb_vr_fifo_flags;
  localparam int unsigned DW = 6, AW = 2, AF = 3, AE = 1, DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [AW:0]   level;
  logic          af, ae;
  logic [DW-1:0] sb_q [$];
  int            m_level;
  int            n_cmp = 0;
  int            n_err = 0;

  vr_fifo_flags_if #(.D_WIDTH(DW)) bus ();

  vr_fifo_flags #(
    .D_WIDTH (DW),
    .A_WIDTH (AW),
    .AF_LEVEL(AF),
    .AE_LEVEL(AE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .bus         (bus),
    .level       (level),
    .almost_full (af),
    .almost_empty(ae)
  );

  always #5 clk = ~clk;

  task automatic set_in(input logic uv, input logic [DW-1:0] ud, input logic dr,
                        input logic fl);
    bus.up_valid   = uv;
    bus.up_data    = ud;
    bus.down_ready = dr;
    flush          = fl;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.up_ready !== 1'b1)
      begin n_err++; $display("FAIL reset_up_ready: got %b want 1", bus.up_ready); end
    n_cmp++; if (bus.down_valid !== 1'b0)
      begin n_err++; $display("FAIL reset_down_valid: got %b want 0", bus.down_valid); end
    n_cmp++; if (level !== 3'd0)
      begin n_err++; $display("FAIL reset_level: got %0d want 0", level); end
    n_cmp++; if (ae !== 1'b1)
      begin n_err++; $display("FAIL reset_almost_empty: got %b want 1", ae); end
    n_cmp++; if (af !== 1'b0)
      begin n_err++; $display("FAIL reset_almost_full: got %b want 0", af); end
    @(negedge clk);
    rst = 1'b0;
    m_level = 0;
    sb_q.delete();
  endtask

  task automatic test_fill();
    logic exp_rdy;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      set_in(1'b1, DW'(i), 1'b0, 1'b0);
      #1;
      exp_rdy = (m_level != DEPTH);
      n_cmp++; if (bus.up_ready !== exp_rdy) begin
        n_err++; $display("FAIL fill_up_ready word %0d: got %b want %b", i, bus.up_ready, exp_rdy);
      end
      if (exp_rdy) begin sb_q.push_back(DW'(i)); m_level++; end
      @(posedge clk); #1;
      n_cmp++; if (level !== 3'(m_level))
        begin n_err++; $display("FAIL fill_level word %0d: got %0d want %0d", i, level, m_level); end
      n_cmp++; if (af !== (m_level >= AF))
        begin n_err++; $display("FAIL fill_almost_full word %0d: got %b", i, af); end
      n_cmp++; if (ae !== (m_level <= AE))
        begin n_err++; $display("FAIL fill_almost_empty word %0d: got %b", i, ae); end
    end
    bus.up_valid = 1'b0;
  endtask

  task automatic test_drain();
    logic [DW-1:0] exp;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_in(1'b0, '0, 1'b1, 1'b0);
      #1;
      n_cmp++; if (bus.down_valid !== 1'b1)
        begin n_err++; $display("FAIL drain_valid pop %0d: got %b want 1", i, bus.down_valid); end
      exp = (sb_q.size() != 0) ? sb_q.pop_front() : 'x;
      n_cmp++; if (bus.down_data !== exp)
        begin n_err++; $display("FAIL drain_data pop %0d: got %h want %h", i, bus.down_data, exp); end
      m_level--;
      @(posedge clk); #1;
      n_cmp++; if (level !== 3'(m_level))
        begin n_err++; $display("FAIL drain_level pop %0d: got %0d want %0d", i, level, m_level); end
    end
    n_cmp++; if (bus.down_valid !== 1'b0)
      begin n_err++; $display("FAIL drain_empty: down_valid got %b want 0", bus.down_valid); end
    bus.down_ready = 1'b0;
  endtask

  task automatic test_stream();
    logic [DW-1:0] exp;
    @(negedge clk);
    set_in(1'b1, 6'h00, 1'b0, 1'b0);
    sb_q.push_back(6'h00);
    @(posedge clk); #1;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (i < 64) set_in(1'b1, DW'(i), 1'b1, 1'b0);
      else        set_in(1'b0, '0, 1'b1, 1'b0);
      #1;
      n_cmp++; if (bus.down_valid !== 1'b1)
        begin n_err++; $display("FAIL stream_valid step %0d: got %b want 1", i, bus.down_valid); end
      exp = (sb_q.size() != 0) ? sb_q.pop_front() : 'x;
      n_cmp++; if (bus.down_data !== exp)
        begin n_err++; $display("FAIL stream_data step %0d: got %h want %h", i, bus.down_data, exp); end
      if (i < 64) begin
        n_cmp++; if (bus.up_ready !== 1'b1)
          begin n_err++; $display("FAIL stream_up_ready step %0d: got %b want 1", i, bus.up_ready); end
        sb_q.push_back(DW'(i));
      end
      @(posedge clk); #1;
      if (i < 64) begin
        n_cmp++; if (level !== 3'd1)
          begin n_err++; $display("FAIL stream_level step %0d: got %0d want 1", i, level); end
      end
    end
    n_cmp++; if (level !== 3'd0 || sb_q.size() != 0)
      begin n_err++; $display("FAIL stream_end: level %0d left %0d want 0/0", level, sb_q.size()); end
    bus.down_ready = 1'b0;
    m_level = 0;
  endtask

  task automatic test_flush();
    logic [DW-1:0] exp;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      set_in(1'b1, DW'(6'h0A + i), 1'b0, 1'b0);
    end
    @(negedge clk);
    set_in(1'b1, 6'h0D, 1'b1, 1'b1);
    #1;
    n_cmp++; if (bus.up_ready !== 1'b0)
      begin n_err++; $display("FAIL flush_up_ready: got %b want 0", bus.up_ready); end
    @(posedge clk); #1;
    n_cmp++; if (level !== 3'd0)
      begin n_err++; $display("FAIL flush_level: got %0d want 0", level); end
    n_cmp++; if (bus.down_valid !== 1'b0)
      begin n_err++; $display("FAIL flush_down_valid: got %b want 0", bus.down_valid); end
    sb_q.delete();
    @(negedge clk);
    set_in(1'b1, 6'h0C, 1'b0, 1'b0);
    sb_q.push_back(6'h0C);
    @(negedge clk);
    set_in(1'b0, '0, 1'b1, 1'b0);
    #1;
    exp = sb_q.pop_front();
    n_cmp++; if (bus.down_valid !== 1'b1 || bus.down_data !== exp)
      begin n_err++; $display("FAIL flush_readback: got v=%b d=%h want 1/%h", bus.down_valid, bus.down_data, exp); end
    @(posedge clk); #1;
    n_cmp++; if (level !== 3'd0)
      begin n_err++; $display("FAIL flush_after_pop_level: got %0d want 0", level); end
    bus.down_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [DW-1:0] exp;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_in(1'b1, DW'(6'h11 + i), 1'b0, 1'b0);
    end
    @(negedge clk);
    bus.up_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (level !== 3'd3)
      begin n_err++; $display("FAIL arst_pre_level: got %0d want 3", level); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (level !== 3'd0 || bus.down_valid !== 1'b0)
      begin n_err++; $display("FAIL arst_state: level %0d valid %b want 0/0", level, bus.down_valid); end
    n_cmp++; if (bus.up_ready !== 1'b1 || ae !== 1'b1 || af !== 1'b0)
      begin n_err++; $display("FAIL arst_flags: rdy %b ae %b af %b want 1/1/0", bus.up_ready, ae, af); end
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    set_in(1'b1, 6'h21, 1'b0, 1'b0);
    sb_q.push_back(6'h21);
    @(negedge clk);
    set_in(1'b0, '0, 1'b1, 1'b0);
    #1;
    exp = sb_q.pop_front();
    n_cmp++; if (bus.down_valid !== 1'b1 || bus.down_data !== exp)
      begin n_err++; $display("FAIL arst_readback: got v=%b d=%h want 1/%h", bus.down_valid, bus.down_data, exp); end
    @(posedge clk); #1;
    n_cmp++; if (bus.down_valid !== 1'b0 || level !== 3'd0)
      begin n_err++; $display("FAIL arst_final: valid %b level %0d want 0/0", bus.down_valid, level); end
    bus.down_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
